power_sequencer: RTL and testbench

- Sequences the LispMachine core through its power lifecycle: power-on, reset hold, boot, run, shutdown, and fault.
- Sits between the board power switch and the core.
- Debounces the switch in both directions and holds the core in reset for a fixed window.
- Hands off to boot with a start/done handshake, then gates run_enable.
- Performs an orderly shutdown on switch-off or when the core halts.

---
 rtl/power_sequencer.sv | 162 ++++++++++++++++
 tb/tb_power_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/power_sequencer.sv
// rtl/power_sequencer.sv - core power lifecycle sequencer: debounce, reset hold, boot handshake, run gating, shutdown, fault
module power_sequencer #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int RESET_HOLD_CYCLES = 8,
    parameter int BOOT_TIMEOUT      = 1024,
    parameter int CNT_W             = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_sw,
    input  logic       boot_done,
    input  logic       machine_halted,
    output logic       machine_power,
    output logic       machine_rst_n,
    output logic       boot_start,
    output logic       run_enable,
    output logic       fault,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_DB_ON    = 3'd1,
        S_RST_HOLD = 3'd2,
        S_BOOT     = 3'd3,
        S_RUN      = 3'd4,
        S_DB_OFF   = 3'd5,
        S_SHUTDOWN = 3'd6,
        S_FAULT    = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             sync1_q, sync2_q;
    logic             power_s;

    assign power_s = sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            sync1_q <= power_sw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        case (state_q)
            S_OFF: begin
                // armed is cleared by a halt so a held-on switch cannot loop halt/reboot
                if (!power_s) armed_d = 1'b1;
                if (armed_q && power_s) begin
                    state_d = S_DB_ON;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_DB_ON: begin
                if (!power_s) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_RST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_BOOT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BOOT: begin
                if (!power_s) begin
                    state_d = S_SHUTDOWN;
                    cnt_d   = '0;
                end else if (boot_done) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == BOOT_LAST) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!power_s) begin
                    state_d = S_DB_OFF;
                    cnt_d   = CNT_W'(1);
                end else if (machine_halted) begin
                    state_d = S_SHUTDOWN;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end
            end
            S_DB_OFF: begin
                if (power_s) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (machine_halted) begin
                    state_d = S_SHUTDOWN;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_SHUTDOWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHUTDOWN: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FAULT: begin
                if (!power_s) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                    armed_d = 1'b1;
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore decode only: no input reaches an output without passing a flop
    assign machine_power = (state_q == S_RST_HOLD) || (state_q == S_BOOT) || (state_q == S_RUN)
                        || (state_q == S_DB_OFF) || (state_q == S_SHUTDOWN);
    assign machine_rst_n = (state_q == S_BOOT) || (state_q == S_RUN) || (state_q == S_DB_OFF);
    assign run_enable    = (state_q == S_RUN) || (state_q == S_DB_OFF);
    assign boot_start    = (state_q == S_BOOT) && (cnt_q == '0);
    assign fault         = (state_q == S_FAULT);
    assign state_out     = state_q;

endmodule

// File: tb/tb_power_sequencer.sv
// tb/tb_power_sequencer.sv - directed and randomized bench for power_sequencer against a lifecycle reference model
module tb_power_sequencer;

    localparam int DEB = 4;
    localparam int RH  = 3;
    localparam int BT  = 10;

    localparam int M_OFF = 0, M_DB_ON = 1, M_RST_HOLD = 2, M_BOOT = 3;
    localparam int M_RUN = 4, M_DB_OFF = 5, M_SHUTDOWN = 6, M_FAULT = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       power_sw = 1'b0;
    logic       boot_done = 1'b0;
    logic       machine_halted = 1'b0;
    logic       machine_power, machine_rst_n, boot_start, run_enable, fault;
    logic [2:0] state_out;

    power_sequencer #(
        .DEBOUNCE_CYCLES  (DEB),
        .RESET_HOLD_CYCLES(RH),
        .BOOT_TIMEOUT     (BT),
        .CNT_W            (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .power_sw      (power_sw),
        .boot_done     (boot_done),
        .machine_halted(machine_halted),
        .machine_power (machine_power),
        .machine_rst_n (machine_rst_n),
        .boot_start    (boot_start),
        .run_enable    (run_enable),
        .fault         (fault),
        .state_out     (state_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: lifecycle phase, time spent in phase, and a sample history for the synchronizer
    int m_phase;
    int m_age;
    int m_streak;
    bit m_armed;
    bit m_hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return {24'd0, state_out, machine_power, machine_rst_n, boot_start, run_enable, fault};
    endfunction

    function automatic logic [31:0] model_outs();
        bit pwr, rn, bs, re, ft;
        pwr = (m_phase >= M_RST_HOLD) && (m_phase <= M_SHUTDOWN);
        rn  = (m_phase == M_BOOT) || (m_phase == M_RUN) || (m_phase == M_DB_OFF);
        re  = (m_phase == M_RUN) || (m_phase == M_DB_OFF);
        bs  = (m_phase == M_BOOT) && (m_age == 0);
        ft  = (m_phase == M_FAULT);
        return {24'd0, 3'(m_phase), pwr, rn, bs, re, ft};
    endfunction

    task automatic model_reset();
        m_phase  = M_OFF;
        m_age    = 0;
        m_streak = 0;
        m_armed  = 1'b1;
        m_hist   = '{1'b0, 1'b0};
    endtask

    task automatic enter(input int ph);
        m_phase = ph;
        m_age   = 0;
    endtask

    task automatic model_step();
        bit ps;
        ps = m_hist[0];
        case (m_phase)
            M_OFF: begin
                if (m_armed && ps) begin enter(M_DB_ON); m_streak = 1; end
                if (!ps) m_armed = 1'b1;
            end
            M_DB_ON: begin
                if (!ps) enter(M_OFF);
                else begin
                    m_streak++;
                    if (m_streak == DEB) enter(M_RST_HOLD);
                end
            end
            M_RST_HOLD: begin
                m_age++;
                if (m_age == RH) enter(M_BOOT);
            end
            M_BOOT: begin
                if (!ps) enter(M_SHUTDOWN);
                else if (boot_done) enter(M_RUN);
                else begin
                    m_age++;
                    if (m_age == BT) enter(M_FAULT);
                end
            end
            M_RUN: begin
                if (!ps) begin enter(M_DB_OFF); m_streak = 1; end
                else if (machine_halted) begin enter(M_SHUTDOWN); m_armed = 1'b0; end
            end
            M_DB_OFF: begin
                if (ps) enter(M_RUN);
                else if (machine_halted) begin enter(M_SHUTDOWN); m_armed = 1'b0; end
                else begin
                    m_streak++;
                    if (m_streak == DEB) enter(M_SHUTDOWN);
                end
            end
            M_SHUTDOWN: begin
                m_age++;
                if (m_age == RH) enter(M_OFF);
            end
            default: begin
                if (!ps) begin enter(M_OFF); m_armed = 1'b1; end
            end
        endcase
        void'(m_hist.pop_front());
        m_hist.push_back(power_sw);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cycle", dut_outs(), model_outs());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int  n;
    bit  run_held, saw_dboff, power_seen;

    initial begin
        model_reset();
        #3;
        check("reset_outs", dut_outs(), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Power-up with boot_done five cycles after boot_start
        power_sw = 1'b1;
        n = 0;
        while (!machine_power && n < 20) begin tick(); n++; end
        check("power_latency", n, 6);
        n = 0;
        while (!machine_rst_n && n < 20) begin tick(); n++; end
        check("rst_hold_len", n, RH);
        check("boot_start_pulse", boot_start, 1);
        ticks(4);
        boot_done = 1'b1;
        tick();
        check("run_state", state_out, M_RUN);
        check("run_enable", run_enable, 1);
        boot_done = 1'b0;
        ticks(3);

        // Run glitch: two low samples must not drop run_enable
        power_sw = 1'b0;
        run_held = 1'b1; saw_dboff = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) power_sw = 1'b1;
            tick();
            run_held  &= run_enable;
            saw_dboff |= (state_out == 3'(M_DB_OFF));
        end
        check("glitch_run_held", run_held, 1);
        check("glitch_saw_dboff", saw_dboff, 1);

        // Switch-off: orderly shutdown then OFF
        power_sw = 1'b0;
        ticks(14);
        check("off_after_shutdown", dut_outs(), 32'd0);

        // Bounce from OFF never powers the core
        power_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            power_sw = (i < 3 || (i >= 4 && i < 7));
            tick();
            power_seen |= machine_power;
        end
        check("bounce_no_power", power_seen, 0);

        // Halt with switch still on, then re-arm by toggling
        power_sw = 1'b1; boot_done = 1'b1;
        ticks(14);
        check("halt_pre_run", state_out, M_RUN);
        machine_halted = 1'b1;
        tick();
        machine_halted = 1'b0;
        ticks(20);
        check("halt_stays_off", dut_outs(), 32'd0);
        power_sw = 1'b0;
        ticks(3);
        power_sw = 1'b1;
        ticks(14);
        check("rearm_run", state_out, M_RUN);

        // Boot timeout to FAULT, cleared by switch-off
        power_sw = 1'b0; boot_done = 1'b0;
        ticks(12);
        power_sw = 1'b1;
        ticks(24);
        check("fault_state", dut_outs(), {24'd0, 3'(M_FAULT), 5'b00001});
        power_sw = 1'b0;
        ticks(4);
        check("fault_cleared", fault, 0);

        // Async reset in RUN drops everything immediately
        power_sw = 1'b1; boot_done = 1'b1;
        ticks(14);
        check("pre_async_run", state_out, M_RUN);
        #2 rst = 1'b0;
        #1 check("async_reset_outs", dut_outs(), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Randomized lifecycle traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) power_sw = ~power_sw;
            boot_done      = ($urandom_range(0, 9) == 0);
            machine_halted = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
